// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: assembles byte-serial features into a parallel bus for
// the decision tree, waits a settle time, captures the class and hands it off
// on a valid/ready port. Frames are length-checked and counted.
module dtree_feature_loader #(
  parameter int N_FEAT  = 45,
  parameter int SETTLE  = 2,
  parameter int CLASS_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [8*N_FEAT-1:0]   feat_bus,
  input  logic [CLASS_W-1:0]    class_in,
  output logic [CLASS_W-1:0]    m_class,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_err,
  output logic [15:0]           ok_count,
  output logic [7:0]            err_count
);

  localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [7:0]    LAST_IDX    = 8'(N_FEAT - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_SETTLE,
    S_OUT
  } state_t;

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic          accept;
  logic          wr_feat;
  logic          capture;
  logic          m_valid_n;
  logic          frame_err_n;
  logic          ok_inc;
  logic          err_inc;

  // Ready depends only on state; held low while reset is asserted.
  assign s_ready = !rst && (state == S_LOAD || state == S_DRAIN);
  assign accept  = s_valid && s_ready;

  // Next-state decode: frame length checks, settle countdown and handshake.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    settle_n    = settle_cnt;
    m_valid_n   = m_valid;
    wr_feat     = 1'b0;
    capture     = 1'b0;
    frame_err_n = 1'b0;
    ok_inc      = 1'b0;
    err_inc     = 1'b0;
    case (state)
      S_LOAD: begin
        if (accept) begin
          wr_feat = 1'b1;
          cnt_n   = 8'd0;
          if (cnt == LAST_IDX) begin
            if (s_last) begin
              state_n  = S_SETTLE;
              settle_n = SETTLE_INIT;
            end else begin
              frame_err_n = 1'b1;
              err_inc     = 1'b1;
              state_n     = S_DRAIN;
            end
          end else if (s_last) begin
            frame_err_n = 1'b1;
            err_inc     = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_last) state_n = S_LOAD;
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          m_valid_n = 1'b1;
          ok_inc    = 1'b1;
          state_n   = S_OUT;
        end else begin
          settle_n = settle_cnt - SW'(1);
        end
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_n = 1'b0;
          state_n   = S_LOAD;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // FSM state, byte index and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      cnt        <= 8'd0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      settle_cnt <= settle_n;
    end
  end

  // Output port registers and saturating frame/error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_class   <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      ok_count  <= 16'd0;
      err_count <= 8'd0;
    end else begin
      m_valid   <= m_valid_n;
      frame_err <= frame_err_n;
      if (capture) m_class <= class_in;
      if (ok_inc && ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Feature slots: only an accepted LOAD byte writes its slot; never cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_bus <= '0;
    end else begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (wr_feat && cnt == 8'(k)) feat_bus[8*k +: 8] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb_dtree_feature_loader: scoreboard-driven bench for the feature loader.
module tb_dtree_feature_loader;

  localparam int N_FEAT  = 45;
  localparam int SETTLE  = 2;
  localparam int CLASS_W = 5;

  logic                clk;
  logic                rst;
  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [8*N_FEAT-1:0] feat_bus;
  logic [CLASS_W-1:0]  class_in;
  logic [CLASS_W-1:0]  m_class;
  logic                m_valid;
  logic                m_ready;
  logic                frame_err;
  logic [15:0]         ok_count;
  logic [7:0]          err_count;

  int checks   = 0;
  int failures = 0;
  int exp_ok   = 0;
  int exp_err  = 0;
  logic [CLASS_W-1:0] exp_q[$];

  dtree_feature_loader #(
    .N_FEAT(N_FEAT), .SETTLE(SETTLE), .CLASS_W(CLASS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .feat_bus(feat_bus), .class_in(class_in),
    .m_class(m_class), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .ok_count(ok_count), .err_count(err_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one byte and returns just after the edge that accepted it.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int waited = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("[TB] FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Holds reset for three edges starting from a post-edge point.
  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold s_ready=%b m_valid=%b required=0/0", s_ready, m_valid);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    exp_q.delete();
    exp_ok  = 0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0;
    class_in = '0; m_ready = 1'b0;
    #1;
    apply_reset();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_err !== 1'b0 || m_class !== '0 ||
        ok_count !== 16'd0 || err_count !== 8'd0 || feat_bus !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values s_ready=%b m_valid=%b frame_err=%b m_class=%0d ok=%0d err=%0d required=1/0/0/0/0/0",
               s_ready, m_valid, frame_err, m_class, ok_count, err_count);
    end
  endtask

  task automatic test_nominal();
    class_in = 5'd13;
    m_ready  = 1'b0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (k == N_FEAT - 1) exp_q.push_back(5'd13);
      send_byte(8'(k + 1), k == N_FEAT - 1);
    end
    exp_ok++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== (c == 3)) begin
        failures++;
        $display("[TB] FAIL nominal_latency cycle=%0d m_valid=%b required=%b", c, m_valid, c == 3);
      end
    end
    checks++;
    if (feat_bus[7:0] !== 8'h01) begin
      failures++;
      $display("[TB] FAIL nominal_slot0 got=%h required=01", feat_bus[7:0]);
    end
    checks++;
    if (feat_bus[359:352] !== 8'h2D) begin
      failures++;
      $display("[TB] FAIL nominal_slot44 got=%h required=2d", feat_bus[359:352]);
    end
    checks++;
    if (feat_bus[8*20 +: 8] !== 8'd21) begin
      failures++;
      $display("[TB] FAIL nominal_slot20 got=%0d required=21", feat_bus[8*20 +: 8]);
    end
    checks++;
    if (m_class !== exp_q[0]) begin
      failures++;
      $display("[TB] FAIL nominal_class got=%0d required=%0d", m_class, exp_q[0]);
    end
    checks++;
    if (ok_count !== 16'(exp_ok)) begin
      failures++;
      $display("[TB] FAIL nominal_ok_count got=%0d required=%0d", ok_count, exp_ok);
    end
  endtask

  task automatic test_backpressure();
    logic [CLASS_W-1:0] exp_cls;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_class !== exp_q[0] || s_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold cycle=%0d m_valid=%b m_class=%0d s_ready=%b required=1/%0d/0",
                 c, m_valid, m_class, s_ready, exp_q[0]);
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    exp_cls = exp_q.pop_front();
    checks++;
    if (m_valid !== 1'b1 || m_class !== exp_cls) begin
      failures++;
      $display("[TB] FAIL bp_handshake m_valid=%b m_class=%0d required=1/%0d", m_valid, m_class, exp_cls);
    end
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_class !== exp_cls) begin
      failures++;
      $display("[TB] FAIL bp_release m_valid=%b s_ready=%b m_class=%0d required=0/1/%0d",
               m_valid, s_ready, m_class, exp_cls);
    end
  endtask

  task automatic test_short_frame();
    int lat;
    logic seen_valid;
    logic [CLASS_W-1:0] exp_cls;
    for (int k = 0; k <= 10; k++) send_byte(8'(8'hA0 + k), k == 10);
    exp_err++;
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("[TB] FAIL short_err frame_err=%b err_count=%0d required=1/%0d", frame_err, err_count, exp_err);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_pulse_width frame_err=%b required=0", frame_err);
    end
    checks++;
    if (feat_bus[7:0] !== 8'hA0 || feat_bus[87:80] !== 8'hAA || feat_bus[95:88] !== 8'd12) begin
      failures++;
      $display("[TB] FAIL short_slots s0=%h s10=%h s11=%h required=a0/aa/0c",
               feat_bus[7:0], feat_bus[87:80], feat_bus[95:88]);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_no_valid m_valid_seen=%b required=0", seen_valid);
    end
    // Following full frame with downstream already ready.
    class_in = 5'd7;
    m_ready  = 1'b1;
    for (int k = 0; k < N_FEAT; k++) begin
      if (k == N_FEAT - 1) exp_q.push_back(5'd7);
      send_byte(8'(k * 3), k == N_FEAT - 1);
    end
    exp_ok++;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 10);
    exp_cls = exp_q.pop_front();
    checks++;
    if (m_valid !== 1'b1 || lat != 3 || m_class !== exp_cls) begin
      failures++;
      $display("[TB] FAIL recover_class m_valid=%b latency=%0d m_class=%0d required=1/3/%0d",
               m_valid, lat, m_class, exp_cls);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || ok_count !== 16'(exp_ok)) begin
      failures++;
      $display("[TB] FAIL recover_oneshot m_valid=%b s_ready=%b ok=%0d required=0/1/%0d",
               m_valid, s_ready, ok_count, exp_ok);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_long_frame();
    class_in = 5'd21;
    for (int k = 0; k < 50; k++) begin
      send_byte(8'(8'h50 + k), k == 49);
      @(negedge clk);
      checks++;
      if (frame_err !== (k == 44)) begin
        failures++;
        $display("[TB] FAIL long_err byte=%0d frame_err=%b required=%b", k, frame_err, k == 44);
      end
    end
    exp_err++;
    checks++;
    if (feat_bus[7:0] !== 8'h50 || feat_bus[15:8] !== 8'h51 || feat_bus[359:352] !== 8'h7C) begin
      failures++;
      $display("[TB] FAIL long_slots s0=%h s1=%h s44=%h required=50/51/7c",
               feat_bus[7:0], feat_bus[15:8], feat_bus[359:352]);
    end
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("[TB] FAIL long_after s_ready=%b m_valid=%b err=%0d required=1/0/%0d",
               s_ready, m_valid, err_count, exp_err);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 8'h33;
    repeat (300) @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    @(negedge clk);
    checks++;
    if (err_count !== 8'(exp_err) || frame_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_err err_count=%0d frame_err=%b required=%0d/1", err_count, frame_err, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    class_in = 5'd9;
    m_ready  = 1'b0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (k == N_FEAT - 1) exp_q.push_back(5'd9);
      send_byte(8'(k + 2), k == N_FEAT - 1);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || ok_count !== 16'(exp_ok) || err_count !== 8'(exp_err) ||
        feat_bus !== '0 || m_class !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_values s_ready=%b m_valid=%b ok=%0d err=%0d m_class=%0d required=1/0/0/0/0",
               s_ready, m_valid, ok_count, err_count, m_class);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_no_valid m_valid_seen=%b required=0", seen_valid);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    rst = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtree_feature_loader.md
# dtree_feature_loader

Byte-serial front end for the combinational decision-tree classifiers. It receives one 8-bit feature per accepted beat and assembles a parallel feature bus for the tree. It then holds the bus stable for a programmable settle time, captures the tree's class output, and presents that class on a valid/ready handshake. It also checks frame framing and keeps saturating frame and error counters.

## Interface
- N_FEAT, 45, features per frame; legal range 2..255
- SETTLE, 2, cycles the feature bus is held stable before class capture; must be ≥1
- CLASS_W, 5, width of the tree class output
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- s_data  in  8  feature byte, unsigned
- s_valid  in  1  s_data valid
- s_last  in  1  marks the final byte of a frame
- s_ready  out  1  loader accepts a byte this cycle
- feat_bus  out  8*N_FEAT  feature k at bits [8k+7:8k]; wired to the tree inputs
- class_in  in  CLASS_W  combinational class from the tree
- m_class  out  CLASS_W  captured class
- m_valid  out  1  m_class valid
- m_ready  in  1  downstream accepts m_class
- frame_err  out  1  one-cycle pulse on a framing error
- ok_count  out  16  completed frames, saturates at 0xFFFF
- err_count  out  8  framing errors, saturates at 0xFF

## Operation
- A byte is accepted in any cycle where s_valid and s_ready are both 1.
- **States:** LOAD, DRAIN, SETTLE, OUT.
- **LOAD** (s_ready=1):
  - An accepted byte is written to feature slot cnt; cnt is 8 bits.
  - If cnt<N_FEAT-1 and s_last=0: cnt increments.
  - If cnt<N_FEAT-1 and s_last=1 (short frame): frame_err pulses, err_count increments, cnt returns to 0, state stays LOAD. Slots already written keep their new values.
  - If cnt==N_FEAT-1 and s_last=1: cnt returns to 0, go to SETTLE with settle counter = SETTLE-1.
  - If cnt==N_FEAT-1 and s_last=0 (long frame): frame_err pulses, err_count increments, cnt returns to 0, go to DRAIN.
- **DRAIN** (s_ready=1):
  - Accepted bytes are discarded; feat_bus is unchanged.
  - An accepted byte with s_last=1 returns the block to LOAD.
  - No further frame_err is raised while draining.
- **SETTLE** (s_ready=0):
  - feat_bus is held.
  - When the settle counter is 0: m_class ← class_in, m_valid ← 1, ok_count increments, go to OUT.
  - Otherwise the settle counter decrements.
- **OUT** (s_ready=0):
  - m_class and m_valid are held until m_ready=1. That cycle completes the handshake: m_valid ← 0, go to LOAD.
  - m_class keeps its last value after the handshake.
- **Outputs:** feat_bus changes only on accepted LOAD bytes; it is never cleared except by reset.
- **Counters:** both saturate. An increment at the maximum value leaves the counter unchanged.
- **Reset:** applies regardless of state, including mid-frame or mid-handshake. A partial frame is discarded; a pending class is dropped without a handshake.

## Timing
- **Reset values:** state LOAD, cnt 0, feat_bus 0, m_class 0, m_valid 0, frame_err 0, ok_count 0, err_count 0. s_ready=0 while rst=1 and 1 in the first cycle after rst falls.
- s_ready is decoded combinationally from state only: 1 in LOAD and DRAIN, 0 in SETTLE and OUT. It never depends on s_valid.
- **Latency:** if the last byte is accepted in cycle t, m_class captures class_in sampled in cycle t+SETTLE and m_valid=1 from cycle t+SETTLE+1.
- feat_bus is stable from cycle t+1 until the next accepted LOAD byte.
- If m_ready is already 1 when m_valid rises, the handshake completes in that same cycle: m_valid is high for exactly one cycle and s_ready=1 the next cycle.
- **Throughput:** at most one frame per N_FEAT+SETTLE+1 cycles.
- frame_err is registered: high for exactly the cycle after the offending byte is accepted, otherwise 0.
- The err_count and ok_count updates become visible on the same edge as the corresponding frame_err or m_valid.

## Test plan
- **Reset:** rst high for 3 cycles in any state → all outputs at their reset values; s_ready=1 in the cycle after release.
- **Nominal frame** (N_FEAT=45, SETTLE=2): send bytes k=0..44 with value k+1 and s_last on byte 44, class_in tied to 13 → feat_bus[7:0]=0x01, feat_bus[359:352]=0x2D; m_valid rises 3 cycles after the last accept with m_class=13; ok_count=1.
- **Backpressure:** hold m_ready=0 for 10 cycles → m_valid and m_class held and s_ready=0 throughout; m_ready=1 → m_valid=0 and s_ready=1 the next cycle.
- **Short frame:** s_last on byte 10 → one frame_err pulse, err_count=1, no m_valid; the next full frame then classifies normally.
- **Long frame:** 50 bytes with s_last on byte 49 → frame_err one cycle after byte 44 is accepted; bytes 45..49 are discarded with feat_bus unchanged; then back in LOAD with err_count=1.
- **Saturation and reset mid-operation:** force 300 short frames → err_count=255. Assert rst during SETTLE → no m_valid and counters return to 0.
